// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: RAM controller status and the machine word.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache: dcache priority,
// with a saturating starvation counter that forces an icache grant.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    arb_state_t      state;
    logic [CW-1:0]   starve_cnt;
    logic            d_req;
    logic            d_done;
    logic            i_done;

    assign d_req  = dREN | dWEN;
    // Completion requires the granted requester to still be asking.
    assign d_done = (state == DGRANT) && d_req && (ramstate == ACCESS);
    assign i_done = (state == IGRANT) && iREN  && (ramstate == ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!iREN)
                        starve_cnt <= '0;
                    if (d_req && !(iREN && starve_cnt == MAX_CNT))
                        state <= DGRANT;
                    else if (iREN)
                        state <= IGRANT;
                end
                DGRANT: begin
                    if (d_done) begin
                        state <= IDLE;
                        if (iREN && starve_cnt != MAX_CNT)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (!d_req || ramstate == ERROR) begin
                        state <= IDLE;
                    end
                end
                IGRANT: begin
                    if (i_done) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end else if (!iREN || ramstate == ERROR) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs follow the grant combinationally so a dropped request
    // releases the RAM enables in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state)
            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                dwait    = !d_done;
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                iwait   = !i_done;
            end
            default: ;
        endcase
    end

endmodule
